// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and shared coordinate types
package vga_timing_pkg;
  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 16;
  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 784;
  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 515;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle from the sync generator to pixel logic
interface vga_sync_gen_if;
  import vga_timing_pkg::*;
  logic       pix_en;
  coord_t     hCount;
  coord_t     vCount;
  logic       hsync;
  logic       vsync;
  logic       bright;
  logic       line_start;
  logic       frame_start;
  frame_cnt_t frame_count;
  modport master (output pix_en, hCount, vCount, hsync, vsync, bright, line_start, frame_start, frame_count);
  modport slave  (input  pix_en, hCount, vCount, hsync, vsync, bright, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis with registered sync and visible-window decodes
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL     = H_TOTAL,
  parameter int SYNC      = H_SYNC,
  parameter int VIS_START = H_VIS_START,
  parameter int VIS_END   = H_VIS_END
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   adv,
  output coord_t count,
  output logic   wrap,
  output logic   sync_n,
  output logic   vis
);
  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t SYNC_END = coord_t'(SYNC);
  localparam coord_t VIS_LO = coord_t'(VIS_START);
  localparam coord_t VIS_HI = coord_t'(VIS_END);
  if (TOTAL > 1024 || !(SYNC < VIS_START && VIS_START < VIS_END && VIS_END <= TOTAL)) begin : g_bad_timing
    $error("vga_axis_counter: illegal timing parameters");
  end
  coord_t count_q, count_d;
  logic   sync_n_q, sync_n_d;
  logic   vis_q, vis_d;
  assign wrap   = count_q == LAST;
  assign count  = count_q;
  assign sync_n = sync_n_q;
  assign vis    = vis_q;
  // next position and decodes of that next position, so decodes move with the count
  always_comb begin
    count_d  = adv ? (wrap ? '0 : count_q + 1'b1) : count_q;
    sync_n_d = !(count_d < SYNC_END);
    vis_d    = count_d >= VIS_LO && count_d < VIS_HI;
  end
  // axis state; reset parks at position 0 with all decodes low
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      sync_n_q <= 1'b0;
      vis_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      vis_q    <= vis_d;
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel divider, H/V raster counters, line/frame strobes and frame counter
module vga_sync_gen
  import vga_timing_pkg::coord_t, vga_timing_pkg::frame_cnt_t;
#(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_VIS_START = vga_timing_pkg::H_VIS_START,
  parameter int H_VIS_END   = vga_timing_pkg::H_VIS_END,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_VIS_START = vga_timing_pkg::V_VIS_START,
  parameter int V_VIS_END   = vga_timing_pkg::V_VIS_END
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master vga
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 2");
  end
  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  frame_cnt_t       frame_count_q, frame_count_d;
  coord_t           h_count, v_count;
  logic             h_wrap, v_wrap, h_sync_n, v_sync_n, h_vis, v_vis, v_adv;
  assign v_adv = pix_en_q & h_wrap;
  vga_axis_counter #(
    .TOTAL(H_TOTAL), .SYNC(H_SYNC), .VIS_START(H_VIS_START), .VIS_END(H_VIS_END)
  ) u_h (
    .clk(clk), .reset(reset), .adv(pix_en_q),
    .count(h_count), .wrap(h_wrap), .sync_n(h_sync_n), .vis(h_vis)
  );
  vga_axis_counter #(
    .TOTAL(V_TOTAL), .SYNC(V_SYNC), .VIS_START(V_VIS_START), .VIS_END(V_VIS_END)
  ) u_v (
    .clk(clk), .reset(reset), .adv(v_adv),
    .count(v_count), .wrap(v_wrap), .sync_n(v_sync_n), .vis(v_vis)
  );
  assign vga.pix_en      = pix_en_q;
  assign vga.hCount      = h_count;
  assign vga.vCount      = v_count;
  assign vga.hsync       = h_sync_n;
  assign vga.vsync       = v_sync_n;
  assign vga.bright      = h_vis & v_vis;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;
  // strobes fire on the same edge the counters wrap, so they mark the first cycle of the new position
  always_comb begin
    div_d         = div_q == DIV_LAST ? '0 : div_q + 1'b1;
    pix_en_d      = div_q == DIV_LAST;
    line_start_d  = v_adv;
    frame_start_d = v_adv & v_wrap;
    frame_count_d = frame_count_q + {{($bits(frame_cnt_t)-1){1'b0}}, frame_start_d};
  end
  // divider, strobe and frame-counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule
